cam_frame_writer: RTL

Downstream stage of the OV7670 byte-capture path: consumes the raw camera byte stream (`href`, `vsync`, `cam_data`) in the `pclk` domain and pairs bytes into RGB565 pixels. Each pixel is reduced to RGB444 and issued as a single-cycle write to the frame-buffer BRAM port, with a linear address. Frame-level status (`frame_done`, `frame_err`) goes to the display/control logic. The block locks to frame boundaries only after sensor configuration completes.

---
 rtl/cam_frame_writer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cam_frame_writer.sv
// -----------------------------------------------------------------------------
// cam_frame_writer
//
// Pairs raw OV7670 bytes into RGB565 pixels, reduces each pixel to RGB444 and
// issues a single-cycle write into the frame-buffer BRAM at a linear address
// (y*H_RES + x). The address is kept incrementally as line_base + x_cnt, so
// no multiplier is needed. The writer only locks to frame boundaries once
// sensor configuration has completed. A malformed frame is flagged with
// frame_err alongside the frame_done pulse.
//
// Parameters
//   H_RES        active pixels per line
//   V_RES        active lines per frame
//   ADDR_W       frame-buffer address width (2^ADDR_W >= H_RES*V_RES)
//
// Ports
//   pclk         camera pixel clock; all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   config_done  high once the sensor register load has finished
//   vsync        high = vertical blanking; fall = frame start, rise = frame end
//   href         high while line bytes are valid
//   cam_data     camera byte, sampled while href = 1
//   fb_we        frame-buffer write strobe, one cycle per pixel
//   fb_addr      linear pixel address
//   fb_data      pixel {R[3:0], G[3:0], B[3:0]}
//   frame_done   one-cycle pulse at the end of a captured frame
//   frame_err    qualifies frame_done: the frame just ended was malformed
//   frame_active high while capturing a frame
// -----------------------------------------------------------------------------
module cam_frame_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              config_done,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        cam_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              frame_active
);

    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);

    localparam logic [XW-1:0]     H_MAX  = XW'(H_RES);
    localparam logic [YW-1:0]     V_MAX  = YW'(V_RES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    localparam logic [1:0] S_WAIT_CFG = 2'd0;
    localparam logic [1:0] S_SYNC     = 2'd1;
    localparam logic [1:0] S_FRAME    = 2'd2;

    // RGB565 -> RGB444 by truncation of each component's low bits.
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

    // Line counter saturates at V_RES so late lines cannot wrap it.
    function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] y);
        return (y == V_MAX) ? y : y + 1'b1;
    endfunction

    logic [1:0]        state, state_n;
    logic              vsync_d, href_d;
    logic [XW-1:0]     x_cnt, x_n;
    logic [YW-1:0]     y_cnt, y_n;
    logic [ADDR_W-1:0] line_base, base_n;
    logic              phase, phase_n;
    logic              err, err_n;
    logic              hi_load;
    logic [7:0]        hi_byte_p0;

    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [11:0]       data_n;
    logic              done_n, ferr_n;

    logic              vs_fall, vs_rise, line_end;

    assign vs_fall  = vsync_d & ~vsync;
    assign vs_rise  = ~vsync_d & vsync;
    assign line_end = href_d & ~href;

    assign frame_active = (state == S_FRAME);

    always_comb begin
        state_n = state;
        x_n     = x_cnt;
        y_n     = y_cnt;
        base_n  = line_base;
        phase_n = phase;
        err_n   = err;
        hi_load = 1'b0;
        we_n    = 1'b0;
        addr_n  = fb_addr;
        data_n  = fb_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;

        if (!config_done) begin
            // Losing configuration abandons any frame in flight: no write,
            // no frame_done, half pixel discarded (phase clears on next entry).
            state_n = S_WAIT_CFG;
        end else begin
            case (state)
                S_WAIT_CFG: state_n = S_SYNC;

                S_SYNC: begin
                    if (vs_fall) begin
                        state_n = S_FRAME;
                        x_n     = '0;
                        y_n     = '0;
                        base_n  = '0;
                        phase_n = 1'b0;
                        err_n   = 1'b0;
                    end
                end

                S_FRAME: begin
                    if (href) begin
                        if (y_cnt == V_MAX) begin
                            // Line beyond the frame: dropped whole.
                            err_n = 1'b1;
                        end else if (!phase) begin
                            hi_load = 1'b1;
                            phase_n = 1'b1;
                        end else begin
                            phase_n = 1'b0;
                            if (x_cnt < H_MAX) begin
                                we_n   = 1'b1;
                                addr_n = line_base + ADDR_W'(x_cnt);
                                data_n = rgb565_to_444({hi_byte_p0, cam_data});
                                x_n    = x_cnt + 1'b1;
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                    end else if (line_end) begin
                        if (x_cnt != H_MAX || phase) begin
                            err_n = 1'b1;
                        end
                        x_n     = '0;
                        phase_n = 1'b0;
                        // line_base only advances with y_cnt, keeping it equal
                        // to y_cnt*H_RES and clear of address overflow.
                        if (y_cnt != V_MAX) begin
                            base_n = line_base + H_STEP;
                        end
                        y_n = sat_inc_y(y_cnt);
                    end

                    // Evaluated on the post-line-end values so a line closing
                    // on the same edge as vsync rise is counted.
                    if (vs_rise) begin
                        done_n  = 1'b1;
                        ferr_n  = err_n | (y_n != V_MAX);
                        state_n = S_SYNC;
                    end
                end

                default: state_n = S_WAIT_CFG;
            endcase
        end
    end

    // Stage p0: high byte of the pixel pair (data only, no reset needed)
    always_ff @(posedge pclk) begin
        if (hi_load) begin
            hi_byte_p0 <= cam_data;
        end
    end

    // Stage p1: control state, counters and registered write/status outputs
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_WAIT_CFG;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            err        <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            vsync_d    <= vsync;
            href_d     <= href;
            x_cnt      <= x_n;
            y_cnt      <= y_n;
            line_base  <= base_n;
            phase      <= phase_n;
            err        <= err_n;
            fb_we      <= we_n;
            fb_addr    <= addr_n;
            fb_data    <= data_n;
            frame_done <= done_n;
            frame_err  <= ferr_n;
        end
    end

endmodule
